// File: rtl/scan_sequencer.sv
// Scan job sequencer: queues jobs in a DEPTH-entry FIFO and steps the scan engine through their frames.
// Optional macro SCAN_SEQ_REPEAT_EN enables per-job frame repeat; without it every job runs one frame.
module scan_sequencer #(
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [127:0]             job_data,
    input  logic [7:0]               job_repeat,
    input  logic                     abort,
    output logic [127:0]             eng_cfg,
    output logic                     eng_start,
    input  logic                     eng_busy,
    output logic                     frame_done,
    output logic                     job_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     seq_busy,
    output logic                     err_timeout
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int CMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int NW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [127:0]  cfg_q, cfg_d;
    logic          start_q, start_d;
    logic          fdone_q, fdone_d;
    logic          jdone_q, jdone_d;
    logic          seq_busy_q, seq_busy_d;
    logic          err_q, err_d;
    logic          aborted_q, aborted_d;
    logic          push, pop;
    logic          more_frames;

`ifdef SCAN_SEQ_REPEAT_EN
    logic [7:0] rep_mem_q [DEPTH];
    logic [7:0] frames_q, frames_d;
    assign more_frames = (frames_q != 8'd0);
`else
    logic unused_repeat;
    assign unused_repeat = ^job_repeat;
    assign more_frames   = 1'b0;
`endif

    assign job_ready = (count_q < CW'(DEPTH)) && !abort;
    assign push      = job_valid && job_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= job_data;
`ifdef SCAN_SEQ_REPEAT_EN
            rep_mem_q[wr_ptr_q] <= job_repeat;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        fdone_d   = 1'b0;
        jdone_d   = 1'b0;
        pop       = 1'b0;
`ifdef SCAN_SEQ_REPEAT_EN
        frames_d  = frames_q;
`endif
        case (state_q)
            IDLE: begin
                aborted_d = 1'b0;
                if (count_q != '0 && !abort) state_d = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    pop     = 1'b1;
                    cfg_d   = mem_q[rd_ptr_q];
                    state_d = START;
`ifdef SCAN_SEQ_REPEAT_EN
                    frames_d = (rep_mem_q[rd_ptr_q] == 8'd0) ? 8'd1 : rep_mem_q[rd_ptr_q];
`endif
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (eng_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == NW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            WAIT_DONE: begin
                // Entry required busy high, so busy low here is the falling edge.
                if (!eng_busy) begin
                    fdone_d = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
`ifdef SCAN_SEQ_REPEAT_EN
                    if (frames_q != 8'd0) frames_d = frames_q - 8'd1;
`endif
                end
            end
            GAP: begin
                if (cnt_q == NW'(GAP_CYCLES - 1)) begin
                    if (more_frames && !abort && !aborted_q) begin
                        state_d = START;
                    end else begin
                        jdone_d = !abort && !aborted_q;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Remembered per job so job_done stays suppressed even if abort drops early.
        if (abort && state_q != IDLE) aborted_d = 1'b1;

        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_d  = count_q + CW'(push) - CW'(pop);
        end

        start_d    = (state_d == START);
        seq_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            start_q    <= 1'b0;
            fdone_q    <= 1'b0;
            jdone_q    <= 1'b0;
            seq_busy_q <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef SCAN_SEQ_REPEAT_EN
            frames_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            start_q    <= start_d;
            fdone_q    <= fdone_d;
            jdone_q    <= jdone_d;
            seq_busy_q <= seq_busy_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;
`ifdef SCAN_SEQ_REPEAT_EN
            frames_q   <= frames_d;
`endif
        end
    end

    assign eng_cfg     = cfg_q;
    assign eng_start   = start_q;
    assign frame_done  = fdone_q;
    assign job_done    = jdone_q;
    assign fifo_count  = count_q;
    assign seq_busy    = seq_busy_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: behavioural engine plus job-level expectation queues.
`timescale 1ns/1ps
module tb_scan_sequencer;
    localparam int DEPTH = 4;
    localparam int GAP   = 16;
    localparam int TMO   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [127:0] job_data;
    logic [7:0]   job_repeat;
    logic         abort;
    logic [127:0] eng_cfg;
    logic         eng_start;
    logic         eng_busy;
    logic         frame_done;
    logic         job_done;
    logic [2:0]   fifo_count;
    logic         seq_busy;
    logic         err_timeout;

    scan_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_data(job_data), .job_repeat(job_repeat), .abort(abort), .eng_cfg(eng_cfg),
        .eng_start(eng_start), .eng_busy(eng_busy), .frame_done(frame_done),
        .job_done(job_done), .fifo_count(fifo_count), .seq_busy(seq_busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log gathered at the falling edge.
    int n_start = 0, n_fdone = 0, n_jdone = 0, n_overlap = 0;
    int t_start = 0, t_fdone = 0, t_jdone = 0;
    int start_times[$];
    int fdone_times[$];
    logic [127:0] cfg_log[$];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (eng_start === 1'b1) begin
                n_start++; t_start = cyc; start_times.push_back(cyc); cfg_log.push_back(eng_cfg);
            end
            if (frame_done === 1'b1) begin
                n_fdone++; t_fdone = cyc; fdone_times.push_back(cyc);
            end
            if (job_done === 1'b1) begin
                n_jdone++; t_jdone = cyc;
            end
            if ((int'(eng_start) + int'(frame_done) + int'(job_done)) > 1) n_overlap++;
        end
    end

    // Engine model: busy rises the cycle after a start pulse and stays high busy_len cycles.
    bit eng_respond = 1'b1;
    bit busy_rand   = 1'b0;
    int busy_len    = 20;
    initial begin
        int len;
        eng_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && eng_respond && reset === 1'b0) begin
                len = busy_rand ? int'($urandom_range(1, 20)) : busy_len;
                @(posedge clk); #1 eng_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 eng_busy = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    function automatic int frames_of(input logic [7:0] r);
        int n;
        n = (r == 8'd0) ? 1 : int'(r);
`ifndef SCAN_SEQ_REPEAT_EN
        n = 1;
`endif
        return n;
    endfunction

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic push_job(input logic [127:0] d, input logic [7:0] r, output bit acc);
        step();
        job_valid  = 1'b1;
        job_data   = d;
        job_repeat = r;
        acc        = job_ready;
        @(posedge clk); #1;
        job_valid  = 1'b0;
    endtask

    task automatic wait_for(input int which, input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if ((which == 0 && n_start >= target) || (which == 1 && n_fdone >= target) ||
                (which == 2 && n_jdone >= target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [127:0] rand_job();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        step();
        total++; if (eng_start !== 1'b0) begin bad++; $display("FAIL rst_eng_start: got %b want 0", eng_start); end
        total++; if (frame_done !== 1'b0 || job_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b%b want 00", frame_done, job_done); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL rst_seq_busy: got %b want 0", seq_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (eng_cfg !== 128'd0) begin bad++; $display("FAIL rst_cfg: got %h want 0", eng_cfg); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        reset = 1'b0;
        step();
        total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rst_job_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_single();
        logic [127:0] d;
        bit acc, ok;
        int s0, f0, j0, ts;
        busy_len = 100;
        s0 = n_start; f0 = n_fdone; j0 = n_jdone;
        d = rand_job();
        push_job(d, 8'd1, acc);
        wait_for(0, s0 + 1, 20, ok);
        ts = t_start;
        total++; if (!ok || seq_busy !== 1'b1) begin bad++; $display("FAIL single_start: ok=%0d seq_busy=%b want 1", ok, seq_busy); end
        wait_for(2, j0 + 1, 300, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_job_done: no job_done within 300 cycles"); end
        total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", n_start - s0); end
        total++; if (n_fdone - f0 !== 1) begin bad++; $display("FAIL single_frames: got %0d want 1", n_fdone - f0); end
        total++; if (t_fdone - ts !== 102) begin bad++; $display("FAIL single_frame_time: got %0d want 102", t_fdone - ts); end
        total++; if (t_jdone - t_fdone !== GAP) begin bad++; $display("FAIL single_gap: got %0d want %0d", t_jdone - t_fdone, GAP); end
        total++; if (cfg_log[cfg_log.size() - 1] !== d) begin bad++; $display("FAIL single_cfg: got %h want %h", cfg_log[cfg_log.size() - 1], d); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", seq_busy); end
    endtask

    task automatic test_repeat();
        logic [127:0] d;
        bit acc, ok;
        int s0, f0, j0, bs, bf, nf;
        busy_len = 30;
        s0 = n_start; f0 = n_fdone; j0 = n_jdone;
        bs = start_times.size(); bf = fdone_times.size();
        nf = frames_of(8'd3);
        d = rand_job();
        push_job(d, 8'd3, acc);
        wait_for(2, j0 + 1, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL repeat_job_done: no job_done within 400 cycles"); end
        total++; if (n_start - s0 !== nf) begin bad++; $display("FAIL repeat_starts: got %0d want %0d", n_start - s0, nf); end
        total++; if (n_fdone - f0 !== nf) begin bad++; $display("FAIL repeat_frames: got %0d want %0d", n_fdone - f0, nf); end
        total++; if (t_jdone - t_fdone !== GAP) begin bad++; $display("FAIL repeat_last_gap: got %0d want %0d", t_jdone - t_fdone, GAP); end
        if (start_times.size() >= bs + nf && fdone_times.size() >= bf + nf) begin
            for (int k = 0; k < nf; k++) begin
                total++; if (fdone_times[bf + k] - start_times[bs + k] !== 32) begin bad++; $display("FAIL repeat_frame_len[%0d]: got %0d want 32", k, fdone_times[bf + k] - start_times[bs + k]); end
                total++; if (cfg_log[bs + k] !== d) begin bad++; $display("FAIL repeat_cfg[%0d]: got %h want %h", k, cfg_log[bs + k], d); end
                if (k > 0) begin
                    total++; if (start_times[bs + k] - fdone_times[bf + k - 1] !== GAP) begin bad++; $display("FAIL repeat_spacing[%0d]: got %0d want %0d", k, start_times[bs + k] - fdone_times[bf + k - 1], GAP); end
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [127:0] exp_q[$];
        logic [127:0] d;
        bit acc, ok;
        bit acc_v[5];
        int s0, j0, bs;
        busy_len = 150;
        s0 = n_start; j0 = n_jdone; bs = cfg_log.size();
        d = rand_job();
        push_job(d, 8'd1, acc);
        exp_q.push_back(d);
        wait_for(0, s0 + 1, 20, ok);
        busy_len = 10;
        for (int i = 0; i < 5; i++) begin
            d = rand_job();
            push_job(d, 8'd1, acc_v[i]);
            if (acc_v[i]) exp_q.push_back(d);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            total++; if (acc_v[i] !== (i < DEPTH)) begin bad++; $display("FAIL full_accept[%0d]: got %0d want %0d", i, acc_v[i], (i < DEPTH)); end
        end
        total++; if (fifo_count !== 3'(DEPTH)) begin bad++; $display("FAIL full_count: got %0d want %0d", fifo_count, DEPTH); end
        total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", job_ready); end
        wait_for(2, j0 + 5, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain: got %0d jobs want 5", n_jdone - j0); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (cfg_log.size() <= bs + i || cfg_log[bs + i] !== exp_q[i]) begin bad++; $display("FAIL full_order[%0d]: job config out of order", i); end
        end
    endtask

    task automatic test_timeout();
        logic [127:0] d;
        bit acc, ok;
        int s0, f0, j0, ts, t_err;
        logic sb;
        eng_respond = 1'b0;
        s0 = n_start; f0 = n_fdone;
        push_job(rand_job(), 8'd1, acc);
        wait_for(0, s0 + 1, 20, ok);
        ts = t_start; t_err = -1; sb = 1'bx;
        for (int i = 0; i < 15; i++) begin
            step();
            if (err_timeout === 1'b1 && t_err < 0) begin t_err = cyc; sb = seq_busy; end
        end
        total++; if (t_err - ts !== TMO + 1) begin bad++; $display("FAIL tmo_time: got %0d want %0d", t_err - ts, TMO + 1); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %b want 0", sb); end
        total++; if (n_fdone !== f0) begin bad++; $display("FAIL tmo_frames: got %0d want %0d", n_fdone, f0); end
        eng_respond = 1'b1;
        busy_len = 12;
        j0 = n_jdone;
        d = rand_job();
        push_job(d, 8'd1, acc);
        wait_for(2, j0 + 1, 100, ok);
        total++; if (!ok || cfg_log[cfg_log.size() - 1] !== d) begin bad++; $display("FAIL tmo_next_job: ok=%0d cfg=%h want %h", ok, cfg_log[cfg_log.size() - 1], d); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_abort();
        bit acc, ok;
        int s0, f0, j0;
        busy_len = 40;
        s0 = n_start; f0 = n_fdone; j0 = n_jdone;
        push_job(rand_job(), 8'd3, acc);
        wait_for(0, s0 + 1, 20, ok);
        push_job(rand_job(), 8'd1, acc);
        push_job(rand_job(), 8'd1, acc);
        repeat (6) step();
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL abort_pre_count: got %0d want 2", fifo_count); end
        abort = 1'b1;
        step();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL abort_flush: got %0d want 0", fifo_count); end
        total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", job_ready); end
        repeat (2) step();
        abort = 1'b0;
        wait_for(1, f0 + 1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_frame_completes: no frame_done within 100 cycles"); end
        repeat (60) step();
        total++; if (n_start !== s0 + 1) begin bad++; $display("FAIL abort_no_start: got %0d starts want %0d", n_start - s0, 1); end
        total++; if (n_jdone !== j0) begin bad++; $display("FAIL abort_no_job_done: got %0d want 0", n_jdone - j0); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", seq_busy); end
    endtask

    task automatic test_random();
        logic [127:0] exp_q[$];
        logic [127:0] d;
        logic [7:0] r;
        bit acc, ok;
        int s0, f0, j0, bs, nfr, tries;
        busy_rand = 1'b1;
        s0 = n_start; f0 = n_fdone; j0 = n_jdone; bs = cfg_log.size(); nfr = 0;
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 30)) step();
            d = rand_job();
            r = 8'($urandom_range(0, 3));
            acc = 1'b0; tries = 0;
            while (!acc && tries < 2000) begin
                push_job(d, r, acc);
                tries++;
            end
            for (int k = 0; k < frames_of(r); k++) exp_q.push_back(d);
            nfr += frames_of(r);
        end
        wait_for(2, j0 + 8, 3000, ok);
        busy_rand = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rand_jobs: got %0d want 8", n_jdone - j0); end
        total++; if (n_fdone - f0 !== nfr) begin bad++; $display("FAIL rand_frames: got %0d want %0d", n_fdone - f0, nfr); end
        total++; if (n_start - s0 !== nfr) begin bad++; $display("FAIL rand_starts: got %0d want %0d", n_start - s0, nfr); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (cfg_log.size() <= bs + i || cfg_log[bs + i] !== exp_q[i]) begin bad++; $display("FAIL rand_cfg[%0d]: frame config differs from job stream", i); end
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rand_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_push_pop();
        bit acc, ok;
        int s0, j0;
        busy_len = 60;
        s0 = n_start; j0 = n_jdone;
        push_job(rand_job(), 8'd1, acc);
        wait_for(0, s0 + 1, 20, ok);
        for (int i = 0; i < 3; i++) push_job(rand_job(), 8'd1, acc);
        step();
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL pp_pre_count: got %0d want 3", fifo_count); end
        wait_for(2, j0 + 1, 200, ok);
        push_job(rand_job(), 8'd1, acc);
        step();
        total++; if (!ok || acc !== 1'b1) begin bad++; $display("FAIL pp_accept: ok=%0d acc=%0d want 1", ok, acc); end
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL pp_count: got %0d want 3", fifo_count); end
        busy_len = 5;
        wait_for(2, j0 + 5, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL pp_drain: got %0d jobs want 5", n_jdone - j0); end
    endtask

    task automatic test_reset_midframe();
        bit acc, ok;
        int s0, f0;
        busy_len = 80;
        s0 = n_start;
        push_job(rand_job(), 8'd1, acc);
        wait_for(0, s0 + 1, 20, ok);
        push_job(rand_job(), 8'd1, acc);
        repeat (5) step();
        reset = 1'b1;
        #1;
        total++; if (eng_start !== 1'b0 || frame_done !== 1'b0 || job_done !== 1'b0) begin bad++; $display("FAIL mid_rst_pulses: got %b%b%b want 000", eng_start, frame_done, job_done); end
        total++; if (seq_busy !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL mid_rst_state: seq_busy=%b count=%0d want 0/0", seq_busy, fifo_count); end
        total++; if (eng_cfg !== 128'd0 || err_timeout !== 1'b0) begin bad++; $display("FAIL mid_rst_regs: cfg=%h err=%b want 0/0", eng_cfg, err_timeout); end
        repeat (2) step();
        reset = 1'b0;
        s0 = n_start; f0 = n_fdone;
        repeat (150) step();
        total++; if (n_start !== s0 || n_fdone !== f0) begin bad++; $display("FAIL mid_rst_quiet: starts=%0d frames=%0d want 0/0", n_start - s0, n_fdone - f0); end
    endtask

    task automatic test_exclusive();
        total++; if (n_overlap !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", n_overlap); end
    endtask

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_data = '0; job_repeat = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_repeat();
        test_fifo_full();
        test_timeout();
        test_abort();
        test_random();
        test_push_pop();
        test_reset_midframe();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
